// File: rtl/clk_div_prog_if.sv
// Ratio-programming channel of clk_div_prog: request (div_val/div_load) and
// the divider's status (div_ready, div_err, cur_div).
interface clk_div_prog_if #(
  parameter int CNT_W = 8
);
  logic [CNT_W-1:0] div_val;
  logic             div_load;
  logic             div_ready;
  logic             div_err;
  logic [CNT_W-1:0] cur_div;

  modport master (
    output div_val, div_load,
    input  div_ready, div_err, cur_div
  );

  modport slave (
    input  div_val, div_load,
    output div_ready, div_err, cur_div
  );
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider, exact 50% duty for odd and even
// ratios; new ratios are applied only at a period boundary.
module clk_div_prog #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  clk_div_prog_if.slave   dif,
  output logic            clk_out,
  output logic            period_start
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cur_div;
  logic [CNT_W-1:0] pending;
  logic             pos_q;
  logic             neg_q;
  logic             div_ready_q;
  logic             div_err_q;

  logic [CNT_W:0]   half;
  logic [CNT_W-1:0] cnt_inc;
  logic             tc;
  logic             apply;
  logic             load_ok;
  logic             load_bad;

  // One extra bit keeps (N+1)>>1 exact at N = 2^CNT_W-1.
  always_comb begin
    half     = ({1'b0, cur_div} + (CNT_W+1)'(1)) >> 1;
    cnt_inc  = cnt + CNT_W'(1);
    tc       = (cnt == cur_div - CNT_W'(1));
    apply    = !div_ready_q && ((state == IDLE) || tc);
    load_ok  = dif.div_load && div_ready_q && (dif.div_val >= CNT_W'(2));
    load_bad = dif.div_load && div_ready_q && (dif.div_val <  CNT_W'(2));
  end

  // NOTE: every register below uses <= so all of them see the pre-edge values
  // of cnt/cur_div/div_ready; blocking here would leak same-edge updates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      pos_q        <= 1'b0;
      cur_div      <= CNT_W'(DEFAULT_DIV);
      pending      <= '0;
      div_ready_q  <= 1'b1;
      div_err_q    <= 1'b0;
      period_start <= 1'b0;
    end else begin
      div_err_q <= load_bad;

      // A load is never applied on its own acceptance edge: apply needs div_ready=0.
      if (apply) begin
        cur_div     <= pending;
        div_ready_q <= 1'b1;
      end else if (load_ok) begin
        pending     <= dif.div_val;
        div_ready_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          cnt <= '0;
          if (en) begin
            state        <= RUN;
            pos_q        <= 1'b1;
            period_start <= 1'b1;
          end else begin
            pos_q        <= 1'b0;
            period_start <= 1'b0;
          end
        end
        RUN: begin
          if (tc) begin
            cnt <= '0;
            if (en) begin
              pos_q        <= 1'b1;
              period_start <= 1'b1;
            end else begin
              state        <= IDLE;
              pos_q        <= 1'b0;
              period_start <= 1'b0;
            end
          end else begin
            cnt          <= cnt_inc;
            pos_q        <= ({1'b0, cnt_inc} < half);
            period_start <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          cnt          <= '0;
          pos_q        <= 1'b0;
          period_start <= 1'b0;
        end
      endcase
    end
  end

  // Half-cycle-delayed copy of pos_q; ANDing it in trims the odd-ratio high
  // phase by half a clock on the leading side.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) neg_q <= 1'b0;
    else      neg_q <= pos_q;
  end

  assign clk_out       = cur_div[0] ? (pos_q & neg_q) : pos_q;
  assign dif.div_ready = div_ready_q;
  assign dif.div_err   = div_err_q;
  assign dif.cur_div   = cur_div;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed scenarios then random
// en/load traffic, compared every half clock against a period-level model.
module tb_clk_div_prog;

  localparam int CNT_W = 8;

  logic clk;
  logic rst;
  logic en;
  logic clk_out;
  logic period_start;

  clk_div_prog_if #(.CNT_W(CNT_W)) dif ();

  clk_div_prog #(.CNT_W(CNT_W), .DEFAULT_DIV(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .dif          (dif),
    .clk_out      (clk_out),
    .period_start (period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: whether a period is running, position k inside it,
  // ratio in force, and the handshake state.
  bit m_run;
  int m_k;
  int m_n;
  int m_pend;
  bit m_ready;
  bit m_err;
  bit m_ps;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_k = 0; m_n = 5; m_pend = 0;
    m_ready = 1; m_err = 0; m_ps = 0;
  endtask

  task automatic model_edge(input bit e, input bit ld, input int v);
    bit tc;
    bit apply_now;
    tc        = m_run && (m_k == m_n - 1);
    apply_now = !m_ready && (!m_run || tc);
    m_err = 0;
    if (apply_now) begin
      m_n = m_pend; m_ready = 1;
    end else if (m_ready && ld) begin
      if (v >= 2) begin m_pend = v; m_ready = 0; end
      else m_err = 1;
    end
    if (!m_run) begin
      m_ps = e;
      if (e) begin m_run = 1; m_k = 0; end
    end else if (tc) begin
      m_ps = e; m_k = 0;
      if (!e) m_run = 0;
    end else begin
      m_k++; m_ps = 0;
    end
  endtask

  // Half-cycle index h counts from the posedge that started the period: even
  // N is high for halves 0..N-1, odd N for halves 1..N (N halves either way).
  function automatic logic exp_clk(input int h);
    if (!m_run) return 1'b0;
    if (m_n % 2 == 0) return logic'(h < m_n);
    return logic'(h >= 1 && h <= m_n);
  endfunction

  task automatic step(input bit e, input bit ld, input int v);
    en = e; dif.div_load = ld; dif.div_val = CNT_W'(v);
    @(posedge clk);
    model_edge(e, ld, v);
    #1;
    check("clk_out_pos",  clk_out,       exp_clk(2 * m_k));
    check("period_start", period_start,  m_ps);
    check("div_ready",    dif.div_ready, m_ready);
    check("div_err",      dif.div_err,   m_err);
    check("cur_div",      dif.cur_div,   m_n);
    @(negedge clk);
    #1;
    check("clk_out_neg",  clk_out,       exp_clk(2 * m_k + 1));
  endtask

  task automatic wait_at(input int n, input int k);
    for (int i = 0; i < 1000 && !(m_run && m_n == n && m_k == k); i++) step(1, 0, 0);
    check("wait_at_timeout", (m_run && m_n == n && m_k == k), 1);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; dif.div_load = 1'b0; dif.div_val = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_clk_out",      clk_out,       0);
    check("rst_period_start", period_start,  0);
    check("rst_div_ready",    dif.div_ready, 1);
    check("rst_div_err",      dif.div_err,   0);
    check("rst_cur_div",      dif.cur_div,   5);
    rst = 1'b1;

    // Default ratio 5 free-running.
    repeat (20) step(1, 0, 0);

    // Retune to 4 mid-period; current period must finish at 5.
    wait_at(5, 2);
    step(1, 1, 4);
    repeat (14) step(1, 0, 0);

    // Illegal ratios 1 and 0.
    step(1, 1, 1);
    step(1, 0, 0);
    step(1, 1, 0);
    step(1, 0, 0);

    // N=7, drop en at cnt=1: the period completes, then idle, then restart.
    step(1, 1, 7);
    wait_at(7, 1);
    step(0, 0, 0);
    for (int i = 0; i < 20 && m_run; i++) step(0, 0, 0);
    check("en_drop_idle", m_run, 0);
    repeat (3) step(0, 0, 0);
    repeat (16) step(1, 0, 0);

    // N=9 with a second load while busy (ignored), then async reset in the high phase.
    step(1, 1, 9);
    step(1, 1, 3);
    wait_at(9, 1);
    check("pre_rst_clk_out", clk_out, 1);
    rst = 1'b0;
    #1;
    check("async_rst_clk_out", clk_out, 0);
    model_reset();
    #1;
    rst = 1'b1;
    check("post_rst_cur_div",   dif.cur_div,   5);
    check("post_rst_div_ready", dif.div_ready, 1);
    repeat (3) step(0, 0, 0);
    repeat (12) step(1, 0, 0);

    // Extreme ratios.
    step(1, 1, 255);
    wait_at(255, 0);
    repeat (2 * 255 + 3) step(1, 0, 0);
    step(1, 1, 2);
    wait_at(2, 0);
    repeat (10) step(1, 0, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit e;
      bit ld;
      int v;
      int sel;
      e   = ($urandom_range(0, 15) != 0);
      ld  = ($urandom_range(0, 7) == 0);
      sel = int'($urandom_range(0, 49));
      if (sel == 0)      v = 0;
      else if (sel == 1) v = 1;
      else if (sel == 2) v = int'($urandom_range(200, 255));
      else               v = int'($urandom_range(2, 16));
      step(e, ld, v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
